simd_fetch_unit: RTL and testbench
==================================

// Module: simd_fetch_unit
// PURPOSE
//  Parametrised front end of the SIMD core: loads operand matrices B then A row-by-row over a
//  valid/ready stream into NxN register banks, then fetches instructions from instruction memory
//  by PC, launches the execute unit and returns its result on a valid/ready output stream.
//  Replaces externally driven row select/mux controls with an internal row counter and FSM.
// PARAMETERS
//  N        2      lanes per row; matrices are NxN (N >= 2, power of 2)
//  DW       32     data word width
//  PCW      8      program counter width; wraps modulo 2**PCW
//  BASE_PC  0      PC value after reset and after START
//  B_TRANS  0      1: B row k is stored as column k (transposed load); 0: stored as row k
//  HALT_OP  32'hFFFF_FFFF  instruction value that ends the program
// PORTS
//  CLK          in   1        clock
//  RSTN         in   1        reset; synchronous, active-high
//  START        in   1        begin program (honoured only in IDLE)
//  MAT_VALID    in   1        MAT_IN row valid
//  MAT_READY    out  1        row accepted when MAT_VALID & MAT_READY
//  MAT_IN       in   N*DW     one row, lane 0 in LSBs
//  PC_INS       out  PCW      instruction memory address
//  INSTR_VALID  in   1        INSTRDATA valid for current PC_INS
//  INSTR_READY  out  1        instruction accepted on INSTR_VALID & INSTR_READY
//  INSTRDATA    in   32       instruction word
//  INSTR        out  32       latched current instruction
//  MAT_A        out  N*N*DW   bank A, element [r][c] at (r*N+c)*DW
//  MAT_B        out  N*N*DW   bank B, same layout
//  EXEC_START   out  1        one-cycle pulse: INSTR/MAT_A/MAT_B stable for execute
//  EXEC_DONE    in   1        execute finished; EXEC_RESULT valid this cycle
//  EXEC_RESULT  in   DW       execute result
//  RES_VALID    out  1        DATAOUT valid
//  RES_READY    in   1        consumer accepts DATAOUT
//  DATAOUT      out  DW       result word
//  BUSY         out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (RSTN=1 at CLK edge): state IDLE, PC_INS=BASE_PC, row counter 0, INSTR=0, MAT_A=MAT_B=0,
//   DATAOUT=0, all handshake outputs and EXEC_START/BUSY 0. Reset wins over every other event,
//   including mid-load or mid-execute; partially loaded banks are cleared.
//  FSM states: IDLE, LOAD_B, LOAD_A, FETCH, EXEC, OUT.
//  IDLE: START -> LOAD_B, row=0, PC_INS=BASE_PC. START outside IDLE ignored.
//  LOAD_B/LOAD_A: MAT_READY=1 (registered-state decode, combinational). Each handshake writes
//   MAT_IN to row `row` (B column `row` if B_TRANS) on the same edge, row++. Handshake with
//   row==N-1: row<=0, LOAD_B->LOAD_A, LOAD_A->FETCH. MAT_VALID without ready: no effect.
//  FETCH: INSTR_READY=1. On handshake INSTR<=INSTRDATA; if INSTRDATA==HALT_OP -> IDLE
//   (PC unchanged), else -> EXEC. Banks unchanged.
//  EXEC: EXEC_START=1 only in first EXEC cycle. EXEC_DONE sampled in every EXEC cycle,
//   including the first; on it DATAOUT<=EXEC_RESULT -> OUT. EXEC_DONE outside EXEC ignored.
//  OUT: RES_VALID=1, DATAOUT held stable until RES_READY. On handshake PC_INS<=PC_INS+1
//   (wrap 2**PCW-1 -> 0, no flag) -> FETCH. Latency: 1 cycle from EXEC_DONE to RES_VALID.
//  Banks hold contents across instructions; reload only via IDLE+START.
//  Widths: no arithmetic besides PC/row increments; row counter is $clog2(N) bits.
// STRUCTURE
//  simd_pkg: fetch_state_t enum, word_t (DW), HALT_OP constant shared with decoder.
//  Sub-module mat_bank (NxN regs, sync clear, row write port, TRANS parameter), instantiated
//   for A (TRANS=0) and B (TRANS=B_TRANS). Top holds FSM, row counter, PC, output regs.
// TESTING (N=2, DW=32, PCW=4, BASE_PC=0 unless stated)
//  1 Reset: RSTN high 2 cycles with MAT_VALID/INSTR_VALID/START high -> all outputs 0, BUSY=0.
//  2 Load: START; B rows {1,2},{3,4}; A rows {5,6},{7,8}, MAT_VALID gapped every other cycle
//    -> MAT_B=[[1,2],[3,4]], MAT_A=[[5,6],[7,8]], state FETCH; with B_TRANS=1 MAT_B=[[1,3],[2,4]].
//  3 Execute: INSTRDATA=5 -> INSTR=5, one EXEC_START pulse; EXEC_DONE=1,EXEC_RESULT=45 in first
//    EXEC cycle -> next cycle RES_VALID=1, DATAOUT=45; RES_READY low 3 cycles -> held; then PC=1.
//  4 PC wrap: 16 instructions each completed -> PC_INS sequence 0..15 then 0.
//  5 Halt: INSTRDATA=HALT_OP at PC=3 -> IDLE, BUSY=0, PC_INS=3; START -> PC_INS=0, LOAD_B.
//  6 Reset mid-load after B row 0 -> MAT_B=0, IDLE; new START reloads cleanly.

Source files
------------

// File: rtl/simd_fetch_unit_pkg.sv
// Shared types and constants for the SIMD fetch front end: FSM state encoding,
// the instruction word type and the default program-terminating opcode.
package simd_fetch_unit_pkg;

    // Instruction words are always 32 bits wide, independent of the data width.
    localparam int WORD_W = 32;

    // Default opcode that ends a program; the decoder uses the same value.
    localparam logic [WORD_W-1:0] HALT_OP_DEF = 32'hFFFF_FFFF;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_FETCH  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_OUT    = 3'd5
    } fetch_state_t;

    // True when the fetched word is the program terminator.
    function automatic logic is_halt(input word_t ins, input word_t halt_op);
        return (ins == halt_op);
    endfunction

endpackage

// File: rtl/simd_fetch_unit_if.sv
// Bundle of every stream and status signal around the fetch unit. The slave
// modport is the fetch unit's view; the master modport is the environment's
// (matrix source, instruction memory, execute unit, result consumer).
interface simd_fetch_unit_if #(
    parameter int N   = 2,
    parameter int DW  = 32,
    parameter int PCW = 8
);
    // Program control
    logic                start;
    logic                busy;

    // Matrix row stream
    logic                mat_valid;
    logic                mat_ready;
    logic [N*DW-1:0]     mat_in;

    // Instruction memory
    logic [PCW-1:0]      pc_ins;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instrdata;

    // Execute unit
    logic [31:0]         instr;
    logic [N*N*DW-1:0]   mat_a;
    logic [N*N*DW-1:0]   mat_b;
    logic                exec_start;
    logic                exec_done;
    logic [DW-1:0]       exec_result;

    // Result stream
    logic                res_valid;
    logic                res_ready;
    logic [DW-1:0]       dataout;

    modport slave (
        input  start, mat_valid, mat_in, instr_valid, instrdata,
               exec_done, exec_result, res_ready,
        output busy, mat_ready, pc_ins, instr_ready, instr,
               mat_a, mat_b, exec_start, res_valid, dataout
    );

    modport master (
        output start, mat_valid, mat_in, instr_valid, instrdata,
               exec_done, exec_result, res_ready,
        input  busy, mat_ready, pc_ins, instr_ready, instr,
               mat_a, mat_b, exec_start, res_valid, dataout
    );

endinterface

// File: rtl/simd_fetch_unit_mat_bank.sv
// NxN operand register bank with one row-wide write port. With TRANS=1 the
// incoming row k is scattered into column k, so the bank holds the transpose
// of the streamed matrix. Synchronous clear empties the whole bank.
module simd_fetch_unit_mat_bank #(
    parameter int N     = 2,
    parameter int DW    = 32,
    parameter bit TRANS = 1'b0,
    localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [RW-1:0]     i_row,
    input  logic [N*DW-1:0]   i_data,
    output logic [N*N*DW-1:0] o_mat
);

    // Element [r][c] lives at bit offset (r*N+c)*DW.
    logic [N*N*DW-1:0] r_mat;

    // Clear or write one row (or one column when transposing) per accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_mat <= '0;
        end else if (i_we) begin
            for (int c = 0; c < N; c++) begin
                if (TRANS) begin
                    r_mat[(c*N + int'(i_row))*DW +: DW] <= i_data[c*DW +: DW];
                end else begin
                    r_mat[(int'(i_row)*N + c)*DW +: DW] <= i_data[c*DW +: DW];
                end
            end
        end
    end

    assign o_mat = r_mat;

endmodule

// File: rtl/simd_fetch_unit.sv
// Front end of the SIMD core. After START it streams matrix B then matrix A in
// row by row, then walks instruction memory from BASE_PC: each fetched word is
// latched, the execute unit is kicked with a one-cycle pulse, and its result is
// offered on the output stream before the PC advances. A HALT_OP word returns
// the unit to IDLE with the PC parked on the halt instruction. The banks keep
// their contents across instructions and are only rewritten by a new START.
//
// Note: i_rstn is an active-high synchronous reset despite its name; the name
// matches the surrounding core's port list.
module simd_fetch_unit
    import simd_fetch_unit_pkg::*;
#(
    parameter int             N       = 2,
    parameter int             DW      = 32,
    parameter int             PCW     = 8,
    parameter logic [PCW-1:0] BASE_PC = '0,
    parameter bit             B_TRANS = 1'b0,
    parameter word_t          HALT_OP = HALT_OP_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    simd_fetch_unit_if.slave      bus
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    // Control state
    fetch_state_t   r_state;
    logic [RW-1:0]  r_row;
    logic [PCW-1:0] r_pc;
    logic           r_exec_start;

    // Data held for the execute unit and the consumer
    word_t          r_instr;
    logic [DW-1:0]  r_dataout;

    // Handshake decodes
    logic w_in_load_b;
    logic w_in_load_a;
    logic w_mat_ready;
    logic w_instr_ready;
    logic w_res_valid;
    logic w_mat_hs;
    logic w_instr_hs;
    logic w_res_hs;
    logic w_last_row;
    logic w_we_a;
    logic w_we_b;

    // Ready/valid outputs are pure decodes of the registered state, so they
    // change only on clock edges and never depend on the partner's signals.
    assign w_in_load_b   = (r_state == ST_LOAD_B);
    assign w_in_load_a   = (r_state == ST_LOAD_A);
    assign w_mat_ready   = w_in_load_b | w_in_load_a;
    assign w_instr_ready = (r_state == ST_FETCH);
    assign w_res_valid   = (r_state == ST_OUT);

    assign w_mat_hs      = bus.mat_valid   & w_mat_ready;
    assign w_instr_hs    = bus.instr_valid & w_instr_ready;
    assign w_res_hs      = bus.res_ready   & w_res_valid;
    assign w_last_row    = (r_row == LAST_ROW);

    // Row writes land on the same edge as the handshake.
    assign w_we_b        = w_mat_hs & w_in_load_b;
    assign w_we_a        = w_mat_hs & w_in_load_a;

    // Sequencer: load B, load A, then fetch/execute/output until HALT_OP.
    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_pc         <= BASE_PC;
            r_exec_start <= 1'b0;
            r_instr      <= '0;
            r_dataout    <= '0;
        end else begin
            // EXEC_START is a single-cycle pulse; it is only set on entry to EXEC.
            r_exec_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_LOAD_B;
                        r_row   <= '0;
                        r_pc    <= BASE_PC;
                    end
                end
                ST_LOAD_B: begin
                    if (w_mat_hs) begin
                        if (w_last_row) begin
                            r_row   <= '0;
                            r_state <= ST_LOAD_A;
                        end else begin
                            r_row   <= r_row + 1'b1;
                        end
                    end
                end
                ST_LOAD_A: begin
                    if (w_mat_hs) begin
                        if (w_last_row) begin
                            r_row   <= '0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_row   <= r_row + 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_instr_hs) begin
                        r_instr <= bus.instrdata;
                        if (is_halt(bus.instrdata, HALT_OP)) begin
                            // PC stays on the halt word so software can see where it stopped.
                            r_state <= ST_IDLE;
                        end else begin
                            r_state      <= ST_EXEC;
                            r_exec_start <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // Done is accepted in every EXEC cycle, including the one
                    // carrying the start pulse, for single-cycle operations.
                    if (bus.exec_done) begin
                        r_dataout <= bus.exec_result;
                        r_state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (w_res_hs) begin
                        // Natural modulo-2**PCW wrap; no overflow indication.
                        r_pc    <= r_pc + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand bank A is always stored in row order.
    simd_fetch_unit_mat_bank #(
        .N     (N),
        .DW    (DW),
        .TRANS (1'b0)
    ) u_bank_a (
        .i_clk  (i_clk),
        .i_clr  (i_rstn),
        .i_we   (w_we_a),
        .i_row  (r_row),
        .i_data (bus.mat_in),
        .o_mat  (bus.mat_a)
    );

    // Operand bank B is optionally transposed on the way in.
    simd_fetch_unit_mat_bank #(
        .N     (N),
        .DW    (DW),
        .TRANS (B_TRANS)
    ) u_bank_b (
        .i_clk  (i_clk),
        .i_clr  (i_rstn),
        .i_we   (w_we_b),
        .i_row  (r_row),
        .i_data (bus.mat_in),
        .o_mat  (bus.mat_b)
    );

    assign bus.mat_ready   = w_mat_ready;
    assign bus.instr_ready = w_instr_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.pc_ins      = r_pc;
    assign bus.instr       = r_instr;
    assign bus.exec_start  = r_exec_start;
    assign bus.dataout     = r_dataout;

endmodule

// File: tb/tb_simd_fetch_unit.sv
// Directed bench for simd_fetch_unit: reset, gapped and back-to-back matrix
// loads (row order and transposed B), single instruction execute with output
// backpressure, PC wrap, halt/restart and reset in the middle of a load.
module tb_simd_fetch_unit;
    import simd_fetch_unit_pkg::*;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int PCW = 4;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    simd_fetch_unit_if #(.N(N), .DW(DW), .PCW(PCW)) u_if ();
    simd_fetch_unit_if #(.N(N), .DW(DW), .PCW(PCW)) u_if_t ();

    simd_fetch_unit #(
        .N(N), .DW(DW), .PCW(PCW), .BASE_PC(4'd0), .B_TRANS(1'b0), .HALT_OP(HALT_OP_DEF)
    ) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (u_if)
    );

    // Second copy with transposed B, driven in lockstep with the first.
    simd_fetch_unit #(
        .N(N), .DW(DW), .PCW(PCW), .BASE_PC(4'd0), .B_TRANS(1'b1), .HALT_OP(HALT_OP_DEF)
    ) u_dut_t (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (u_if_t)
    );

    assign u_if_t.start       = u_if.start;
    assign u_if_t.mat_valid   = u_if.mat_valid;
    assign u_if_t.mat_in      = u_if.mat_in;
    assign u_if_t.instr_valid = u_if.instr_valid;
    assign u_if_t.instrdata   = u_if.instrdata;
    assign u_if_t.exec_done   = u_if.exec_done;
    assign u_if_t.exec_result = u_if.exec_result;
    assign u_if_t.res_ready   = u_if.res_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction through FETCH/EXEC/OUT; done comes after 'delay' extra EXEC cycles.
    task automatic run_instr(input logic [31:0] ins, input logic [DW-1:0] res, input int delay);
        u_if.instrdata = ins;
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        repeat (delay) tick();
        u_if.exec_done = 1'b1;
        u_if.exec_result = res;
        tick();
        u_if.exec_done = 1'b0;
        u_if.res_ready = 1'b1;
        tick();
        u_if.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        u_if.start = 1'b1;
        u_if.mat_valid = 1'b1;
        u_if.instr_valid = 1'b1;
        u_if.instrdata = 32'h5;
        u_if.mat_in = '1;
        tick();
        tick();
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", u_if.busy); end
        checks++; if (u_if.mat_ready !== 1'b0) begin errors++; $display("FAIL reset_mat_ready got %0h exp 0", u_if.mat_ready); end
        checks++; if (u_if.instr_ready !== 1'b0) begin errors++; $display("FAIL reset_instr_ready got %0h exp 0", u_if.instr_ready); end
        checks++; if (u_if.exec_start !== 1'b0) begin errors++; $display("FAIL reset_exec_start got %0h exp 0", u_if.exec_start); end
        checks++; if (u_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0h exp 0", u_if.res_valid); end
        checks++; if (u_if.pc_ins !== 4'd0) begin errors++; $display("FAIL reset_pc got %0h exp 0", u_if.pc_ins); end
        checks++; if (u_if.instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %0h exp 0", u_if.instr); end
        checks++; if (u_if.dataout !== 32'd0) begin errors++; $display("FAIL reset_dataout got %0h exp 0", u_if.dataout); end
        checks++; if (u_if.mat_a !== 128'd0) begin errors++; $display("FAIL reset_mat_a got %0h exp 0", u_if.mat_a); end
        checks++; if (u_if.mat_b !== 128'd0) begin errors++; $display("FAIL reset_mat_b got %0h exp 0", u_if.mat_b); end
        rstn = 1'b0;
        u_if.start = 1'b0;
        u_if.mat_valid = 1'b0;
        u_if.instr_valid = 1'b0;
        u_if.instrdata = '0;
        u_if.mat_in = '0;
    endtask

    task automatic test_load();
        logic [N*DW-1:0] rows [4];
        rows[0] = {32'd2, 32'd1};
        rows[1] = {32'd4, 32'd3};
        rows[2] = {32'd6, 32'd5};
        rows[3] = {32'd8, 32'd7};
        // Row offered while IDLE must be ignored.
        u_if.mat_in = {32'hDEAD, 32'hBEEF};
        u_if.mat_valid = 1'b1;
        tick();
        checks++; if (u_if.mat_ready !== 1'b0) begin errors++; $display("FAIL idle_mat_ready got %0h exp 0", u_if.mat_ready); end
        u_if.mat_valid = 1'b0;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL load_busy got %0h exp 1", u_if.busy); end
        checks++; if (u_if.mat_ready !== 1'b1) begin errors++; $display("FAIL load_mat_ready got %0h exp 1", u_if.mat_ready); end
        for (int r = 0; r < 4; r++) begin
            u_if.mat_valid = 1'b0;
            tick();
            u_if.mat_in = rows[r];
            u_if.mat_valid = 1'b1;
            tick();
        end
        u_if.mat_valid = 1'b0;
        checks++; if (u_if.mat_b !== {32'd4, 32'd3, 32'd2, 32'd1}) begin errors++; $display("FAIL load_mat_b got %0h exp 4_3_2_1", u_if.mat_b); end
        checks++; if (u_if.mat_a !== {32'd8, 32'd7, 32'd6, 32'd5}) begin errors++; $display("FAIL load_mat_a got %0h exp 8_7_6_5", u_if.mat_a); end
        checks++; if (u_if_t.mat_b !== {32'd4, 32'd2, 32'd3, 32'd1}) begin errors++; $display("FAIL load_mat_b_trans got %0h exp 4_2_3_1", u_if_t.mat_b); end
        checks++; if (u_if_t.mat_a !== {32'd8, 32'd7, 32'd6, 32'd5}) begin errors++; $display("FAIL load_mat_a_trans got %0h exp 8_7_6_5", u_if_t.mat_a); end
        checks++; if (u_if.instr_ready !== 1'b1) begin errors++; $display("FAIL load_fetch_state got %0h exp 1", u_if.instr_ready); end
        checks++; if (u_if.mat_ready !== 1'b0) begin errors++; $display("FAIL load_done_mat_ready got %0h exp 0", u_if.mat_ready); end
    endtask

    task automatic test_execute();
        checks++; if (u_if.pc_ins !== 4'd0) begin errors++; $display("FAIL exec_pc0 got %0h exp 0", u_if.pc_ins); end
        u_if.instrdata = 32'd5;
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        checks++; if (u_if.instr !== 32'd5) begin errors++; $display("FAIL exec_instr got %0h exp 5", u_if.instr); end
        checks++; if (u_if.exec_start !== 1'b1) begin errors++; $display("FAIL exec_start_pulse got %0h exp 1", u_if.exec_start); end
        checks++; if (u_if.instr_ready !== 1'b0) begin errors++; $display("FAIL exec_instr_ready got %0h exp 0", u_if.instr_ready); end
        u_if.exec_done = 1'b1;
        u_if.exec_result = 32'd45;
        tick();
        checks++; if (u_if.res_valid !== 1'b1) begin errors++; $display("FAIL exec_res_valid got %0h exp 1", u_if.res_valid); end
        checks++; if (u_if.dataout !== 32'd45) begin errors++; $display("FAIL exec_dataout got %0d exp 45", u_if.dataout); end
        checks++; if (u_if.exec_start !== 1'b0) begin errors++; $display("FAIL exec_start_single got %0h exp 0", u_if.exec_start); end
        // Done pulses with a new value while in OUT must not disturb the held result.
        u_if.exec_result = 32'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (u_if.res_valid !== 1'b1) begin errors++; $display("FAIL hold_res_valid got %0h exp 1", u_if.res_valid); end
            checks++; if (u_if.dataout !== 32'd45) begin errors++; $display("FAIL hold_dataout got %0d exp 45", u_if.dataout); end
            checks++; if (u_if.pc_ins !== 4'd0) begin errors++; $display("FAIL hold_pc got %0h exp 0", u_if.pc_ins); end
        end
        u_if.exec_done = 1'b0;
        u_if.res_ready = 1'b1;
        tick();
        u_if.res_ready = 1'b0;
        checks++; if (u_if.pc_ins !== 4'd1) begin errors++; $display("FAIL exec_pc_inc got %0h exp 1", u_if.pc_ins); end
        checks++; if (u_if.res_valid !== 1'b0) begin errors++; $display("FAIL exec_res_drop got %0h exp 0", u_if.res_valid); end
        checks++; if (u_if.instr_ready !== 1'b1) begin errors++; $display("FAIL exec_back_fetch got %0h exp 1", u_if.instr_ready); end
    endtask

    task automatic test_pc_wrap();
        logic [PCW-1:0] exp_pc;
        logic [31:0]    exp_ins;
        logic [DW-1:0]  exp_res;
        for (int i = 0; i < 16; i++) begin
            exp_pc  = PCW'(i + 1);
            exp_ins = 32'h100 + 32'(i);
            exp_res = 32'd7 + 32'(i * 3);
            checks++; if (u_if.pc_ins !== exp_pc) begin errors++; $display("FAIL wrap_pc got %0h exp %0h", u_if.pc_ins, exp_pc); end
            run_instr(exp_ins, exp_res, i % 3);
            checks++; if (u_if.dataout !== exp_res) begin errors++; $display("FAIL wrap_dataout got %0h exp %0h", u_if.dataout, exp_res); end
            checks++; if (u_if.instr !== exp_ins) begin errors++; $display("FAIL wrap_instr got %0h exp %0h", u_if.instr, exp_ins); end
        end
        checks++; if (u_if.pc_ins !== 4'd1) begin errors++; $display("FAIL wrap_final_pc got %0h exp 1", u_if.pc_ins); end
    endtask

    task automatic test_halt();
        run_instr(32'h21, 32'h11, 0);
        run_instr(32'h22, 32'h12, 1);
        checks++; if (u_if.pc_ins !== 4'd3) begin errors++; $display("FAIL halt_pc_before got %0h exp 3", u_if.pc_ins); end
        u_if.instrdata = HALT_OP_DEF;
        u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL halt_busy got %0h exp 0", u_if.busy); end
        checks++; if (u_if.pc_ins !== 4'd3) begin errors++; $display("FAIL halt_pc got %0h exp 3", u_if.pc_ins); end
        checks++; if (u_if.instr !== HALT_OP_DEF) begin errors++; $display("FAIL halt_instr got %0h exp ffffffff", u_if.instr); end
        checks++; if (u_if.exec_start !== 1'b0) begin errors++; $display("FAIL halt_no_exec got %0h exp 0", u_if.exec_start); end
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        checks++; if (u_if.pc_ins !== 4'd0) begin errors++; $display("FAIL restart_pc got %0h exp 0", u_if.pc_ins); end
        checks++; if (u_if.mat_ready !== 1'b1) begin errors++; $display("FAIL restart_load_b got %0h exp 1", u_if.mat_ready); end
        checks++; if (u_if.mat_a !== {32'd8, 32'd7, 32'd6, 32'd5}) begin errors++; $display("FAIL restart_banks_kept got %0h exp 8_7_6_5", u_if.mat_a); end
    endtask

    task automatic test_reset_mid_load();
        logic [N*DW-1:0] rows [4];
        rows[0] = {32'd12, 32'd11};
        rows[1] = {32'd14, 32'd13};
        rows[2] = {32'd16, 32'd15};
        rows[3] = {32'd18, 32'd17};
        // Unit is in LOAD_B at row 0 here.
        u_if.mat_in = {32'd10, 32'd9};
        u_if.mat_valid = 1'b1;
        tick();
        u_if.mat_valid = 1'b0;
        checks++; if (u_if.mat_b !== {32'd4, 32'd3, 32'd10, 32'd9}) begin errors++; $display("FAIL midload_row0 got %0h exp 4_3_a_9", u_if.mat_b); end
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        checks++; if (u_if.mat_b !== 128'd0) begin errors++; $display("FAIL midload_clear_b got %0h exp 0", u_if.mat_b); end
        checks++; if (u_if.mat_a !== 128'd0) begin errors++; $display("FAIL midload_clear_a got %0h exp 0", u_if.mat_a); end
        checks++; if (u_if_t.mat_b !== 128'd0) begin errors++; $display("FAIL midload_clear_b_trans got %0h exp 0", u_if_t.mat_b); end
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL midload_idle got %0h exp 0", u_if.busy); end
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        // Back-to-back rows with valid held high.
        u_if.mat_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            u_if.mat_in = rows[r];
            tick();
        end
        u_if.mat_valid = 1'b0;
        checks++; if (u_if.mat_b !== {32'd14, 32'd13, 32'd12, 32'd11}) begin errors++; $display("FAIL reload_mat_b got %0h exp e_d_c_b", u_if.mat_b); end
        checks++; if (u_if.mat_a !== {32'd18, 32'd17, 32'd16, 32'd15}) begin errors++; $display("FAIL reload_mat_a got %0h exp 12_11_10_f", u_if.mat_a); end
        checks++; if (u_if_t.mat_b !== {32'd14, 32'd12, 32'd13, 32'd11}) begin errors++; $display("FAIL reload_mat_b_trans got %0h exp e_c_d_b", u_if_t.mat_b); end
        checks++; if (u_if.instr_ready !== 1'b1) begin errors++; $display("FAIL reload_fetch got %0h exp 1", u_if.instr_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b1;
        u_if.start = 1'b0;
        u_if.mat_valid = 1'b0;
        u_if.mat_in = '0;
        u_if.instr_valid = 1'b0;
        u_if.instrdata = '0;
        u_if.exec_done = 1'b0;
        u_if.exec_result = '0;
        u_if.res_ready = 1'b0;

        test_reset();
        test_load();
        test_execute();
        test_pc_wrap();
        test_halt();
        test_reset_mid_load();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
